active_list: RTL and testbench

//  In-order active list (reorder buffer) of the out-of-order MIPS core. Sits in dispatch, directly

---
 rtl/active_list_pkg.sv | 20 ++
 rtl/active_list_if.sv | 46 ++++
 rtl/active_list.sv | 80 ++++++++
 tb/tb_active_list.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/active_list_pkg.sv
// rtl/active_list_pkg.sv - shared types and sizing for the core active list
package active_list_pkg;

  localparam int ACTIVE_LIST_DEPTH = 32;
  localparam int ACTIVE_LIST_IDXW  = $clog2(ACTIVE_LIST_DEPTH);

  typedef logic [ACTIVE_LIST_IDXW-1:0] active_list_idx_t;

  // Status bits first so the valid/done/mispredict trio sits together at the top
  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    logic        is_branch;
    logic        uses_rw;
    logic [4:0]  rw_addr;
    logic [31:0] pc;
  } active_list_entry_t;

endpackage

// File: rtl/active_list_if.sv
// rtl/active_list_if.sv - dispatch/execute/commit signal bundle for the active list
interface active_list_if import active_list_pkg::*; #(
  parameter int DEPTH = ACTIVE_LIST_DEPTH
) ();

  localparam int IDXW = $clog2(DEPTH);

  logic            alloc_valid;
  logic            alloc_ready;
  logic [31:0]     alloc_pc;
  logic            alloc_uses_rw;
  logic [4:0]      alloc_rw_addr;
  logic            alloc_is_branch;
  logic [IDXW-1:0] alloc_index;

  logic            complete_valid;
  logic [IDXW-1:0] complete_index;
  logic            complete_mispredict;

  logic            retire_valid;
  logic [IDXW-1:0] retire_index;
  logic [31:0]     retire_pc;
  logic            retire_uses_rw;
  logic [4:0]      retire_rw_addr;

  logic            flush_o;
  logic            flush_i;
  logic [IDXW:0]   count;

  // Pipeline side: dispatch, execute units and exception logic
  modport master (
    output alloc_valid, alloc_pc, alloc_uses_rw, alloc_rw_addr, alloc_is_branch,
    output complete_valid, complete_index, complete_mispredict, flush_i,
    input  alloc_ready, alloc_index, retire_valid, retire_index, retire_pc,
    input  retire_uses_rw, retire_rw_addr, flush_o, count
  );

  // Active list side
  modport slave (
    input  alloc_valid, alloc_pc, alloc_uses_rw, alloc_rw_addr, alloc_is_branch,
    input  complete_valid, complete_index, complete_mispredict, flush_i,
    output alloc_ready, alloc_index, retire_valid, retire_index, retire_pc,
    output retire_uses_rw, retire_rw_addr, flush_o, count
  );

endinterface

// File: rtl/active_list.sv
// rtl/active_list.sv - in-order active list (reorder buffer) with in-order retire and flush
module active_list import active_list_pkg::*; #(
  parameter int DEPTH = ACTIVE_LIST_DEPTH
) (
  input logic         clk,
  input logic         rst_n,
  active_list_if.slave al
);

  localparam int IDXW = $clog2(DEPTH);
  localparam logic [IDXW:0] FULL = (IDXW+1)'(DEPTH);

  active_list_entry_t entries [DEPTH];
  logic [IDXW-1:0]    head;
  logic [IDXW-1:0]    tail;
  logic [IDXW:0]      cnt;

  active_list_entry_t head_e;
  logic               do_alloc;
  logic               do_retire;
  logic               do_flush;

  // Handshake decode and commit outputs, all from registered state plus this cycle's inputs
  always_comb begin
    head_e    = entries[head];
    do_retire = head_e.valid && head_e.done && !al.flush_i;
    do_flush  = al.flush_i || (do_retire && head_e.mispredict);

    // Occupancy before this cycle's retire: a full list stays blocked while it retires
    al.alloc_ready = (cnt < FULL) && !do_flush;
    do_alloc       = al.alloc_valid && al.alloc_ready;
    al.alloc_index = tail;

    al.retire_valid   = do_retire;
    al.retire_index   = head;
    al.retire_pc      = do_retire ? head_e.pc      : 32'd0;
    al.retire_uses_rw = do_retire ? head_e.uses_rw : 1'b0;
    al.retire_rw_addr = do_retire ? head_e.rw_addr : 5'd0;
    al.flush_o        = do_retire && head_e.mispredict;
    al.count          = cnt;
  end

  // Entry array, head/tail pointers and occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (do_flush) begin
      // Everything in flight is discarded, including this cycle's alloc and complete
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      if (al.complete_valid && entries[al.complete_index].valid) begin
        entries[al.complete_index].done       <= 1'b1;
        entries[al.complete_index].mispredict <= al.complete_mispredict &&
                                                 entries[al.complete_index].is_branch;
      end
      if (do_retire) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (do_alloc) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                           is_branch: al.alloc_is_branch, uses_rw: al.alloc_uses_rw,
                           rw_addr: al.alloc_rw_addr, pc: al.alloc_pc};
        tail <= tail + 1'b1;
      end
      case ({do_alloc, do_retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_active_list.sv
// tb/tb_active_list.sv - self-checking bench for the active list
module tb_active_list;
  import active_list_pkg::*;

  localparam int D = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  active_list_if #(.DEPTH(D)) al ();

  active_list #(.DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .al    (al)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: program-order queue of live indices ----------------
  int          q[$];
  int          m_next = 0;
  bit          m_done [D];
  bit          m_mis  [D];
  bit          m_br   [D];
  bit          m_live [D];
  bit          m_uses [D];
  logic [4:0]  m_rw   [D];
  logic [31:0] m_pc   [D];
  int          ci;

  function automatic bit e_rv();
    return (q.size() > 0) && m_done[q[0]] && !al.flush_i;
  endfunction

  function automatic bit e_fo();
    return e_rv() && m_mis[q[0]];
  endfunction

  function automatic bit e_ar();
    return (q.size() < D) && !al.flush_i && !e_fo();
  endfunction

  task automatic m_clear();
    q.delete();
    m_next = 0;
    for (int i = 0; i < D; i++) m_live[i] = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear();
    end else if (al.flush_i || e_fo()) begin
      m_clear();
    end else begin
      bit rv, ar;
      rv = e_rv();
      ar = e_ar();
      ci = int'(al.complete_index);
      if (al.complete_valid && m_live[ci]) begin
        m_done[ci] = 1'b1;
        m_mis[ci]  = al.complete_mispredict && m_br[ci];
      end
      if (rv) begin
        m_live[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (al.alloc_valid && ar) begin
        m_live[m_next] = 1'b1;
        m_done[m_next] = 1'b0;
        m_mis[m_next]  = 1'b0;
        m_br[m_next]   = al.alloc_is_branch;
        m_uses[m_next] = al.alloc_uses_rw;
        m_rw[m_next]   = al.alloc_rw_addr;
        m_pc[m_next]   = al.alloc_pc;
        q.push_back(m_next);
        m_next = (m_next + 1) % D;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_alloc_ready", 32'(al.alloc_ready), 32'(e_ar()));
    chk("m_alloc_index", 32'(al.alloc_index), 32'(m_next));
    chk("m_count", 32'(al.count), 32'(q.size()));
    chk("m_retire_valid", 32'(al.retire_valid), 32'(e_rv()));
    chk("m_flush_o", 32'(al.flush_o), 32'(e_fo()));
    if (e_rv()) begin
      chk("m_retire_index", 32'(al.retire_index), 32'(q[0]));
      chk("m_retire_pc", al.retire_pc, m_pc[q[0]]);
      chk("m_retire_uses_rw", 32'(al.retire_uses_rw), 32'(m_uses[q[0]]));
      chk("m_retire_rw_addr", 32'(al.retire_rw_addr), 32'(m_rw[q[0]]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] pc, input logic u,
                           input logic [4:0] rw, input logic br);
    al.alloc_valid     = v;
    al.alloc_pc        = pc;
    al.alloc_uses_rw   = u;
    al.alloc_rw_addr   = rw;
    al.alloc_is_branch = br;
  endtask

  task automatic set_cmp(input logic v, input active_list_idx_t idx, input logic mis);
    al.complete_valid      = v;
    al.complete_index      = idx;
    al.complete_mispredict = mis;
  endtask

  task automatic pulse_flush();
    al.flush_i = 1'b1;
    tick();
    al.flush_i = 1'b0;
  endtask

  initial begin
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    set_cmp(1'b0, '0, 1'b0);
    al.flush_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_alloc_ready", 32'(al.alloc_ready), 32'd1);
    chk("rst_alloc_index", 32'(al.alloc_index), 32'd0);
    chk("rst_count", 32'(al.count), 32'd0);
    chk("rst_retire_valid", 32'(al.retire_valid), 32'd0);
    chk("rst_flush_o", 32'(al.flush_o), 32'd0);
    chk("rst_retire_pc", al.retire_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle after reset
    repeat (10) tick();
    chk("t1_count", 32'(al.count), 32'd0);
    chk("t1_alloc_index", 32'(al.alloc_index), 32'd0);

    // 2: three allocs, out-of-order completion, in-order retire
    set_alloc(1'b1, 32'h100, 1'b1, 5'd3, 1'b0); #1;
    chk("t2_idx0", 32'(al.alloc_index), 32'd0);
    tick();
    set_alloc(1'b1, 32'h104, 1'b0, 5'd4, 1'b0); #1;
    chk("t2_idx1", 32'(al.alloc_index), 32'd1);
    tick();
    set_alloc(1'b1, 32'h108, 1'b1, 5'd5, 1'b0); #1;
    chk("t2_idx2", 32'(al.alloc_index), 32'd2);
    tick();
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    chk("t2_count3", 32'(al.count), 32'd3);
    set_cmp(1'b1, 5'd2, 1'b0); tick();
    chk("t2_no_retire_idx2_first", 32'(al.retire_valid), 32'd0);
    set_cmp(1'b1, 5'd0, 1'b0); tick();
    set_cmp(1'b0, '0, 1'b0);
    chk("t2_ret0_valid", 32'(al.retire_valid), 32'd1);
    chk("t2_ret0_pc", al.retire_pc, 32'h100);
    chk("t2_ret0_rw", 32'(al.retire_rw_addr), 32'd3);
    tick();
    chk("t2_idx1_blocks", 32'(al.retire_valid), 32'd0);
    chk("t2_count2", 32'(al.count), 32'd2);
    set_cmp(1'b1, 5'd1, 1'b0); tick();
    set_cmp(1'b0, '0, 1'b0);
    chk("t2_ret1_pc", al.retire_pc, 32'h104);
    tick();
    chk("t2_ret2_pc", al.retire_pc, 32'h108);
    chk("t2_ret2_index", 32'(al.retire_index), 32'd2);
    tick();
    chk("t2_count0", 32'(al.count), 32'd0);
    pulse_flush();
    chk("t2_flush_idx", 32'(al.alloc_index), 32'd0);

    // 3: fill all 32 entries, then retire one while dispatch keeps pushing
    for (int i = 0; i < D; i++) begin
      set_alloc(1'b1, 32'h1000 + 32'(4 * i), 1'(i), 5'(i), 1'b0);
      tick();
    end
    chk("t3_count_full", 32'(al.count), 32'd32);
    chk("t3_ready_full", 32'(al.alloc_ready), 32'd0);
    chk("t3_index_wrap", 32'(al.alloc_index), 32'd0);
    set_cmp(1'b1, 5'd0, 1'b0); tick();
    set_cmp(1'b0, '0, 1'b0);
    chk("t3_retire_valid", 32'(al.retire_valid), 32'd1);
    chk("t3_ready_on_retire", 32'(al.alloc_ready), 32'd0);
    tick();
    chk("t3_ready_after", 32'(al.alloc_ready), 32'd1);
    chk("t3_count31", 32'(al.count), 32'd31);
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    pulse_flush();

    // 4: mispredicted branch retires and flushes
    set_alloc(1'b1, 32'h2000, 1'b0, 5'd0, 1'b1); tick();
    for (int i = 1; i < 5; i++) begin
      set_alloc(1'b1, 32'h2000 + 32'(4 * i), 1'b1, 5'(i + 8), 1'b0);
      tick();
    end
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    set_cmp(1'b1, 5'd0, 1'b1); tick();
    set_cmp(1'b1, 5'd3, 1'b0);
    chk("t4_flush_o", 32'(al.flush_o), 32'd1);
    chk("t4_retire_pc", al.retire_pc, 32'h2000);
    chk("t4_ready_in_flush", 32'(al.alloc_ready), 32'd0);
    tick();
    chk("t4_count0", 32'(al.count), 32'd0);
    chk("t4_tail0", 32'(al.alloc_index), 32'd0);
    tick();
    set_cmp(1'b0, '0, 1'b0);
    chk("t4_stale_ignored", 32'(al.retire_valid), 32'd0);
    // mispredict on a non-branch is not a flush
    set_alloc(1'b1, 32'h3000, 1'b1, 5'd7, 1'b0); tick();
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    set_cmp(1'b1, 5'd0, 1'b1); tick();
    set_cmp(1'b0, '0, 1'b0);
    chk("t4_nb_retire", 32'(al.retire_valid), 32'd1);
    chk("t4_nb_no_flush", 32'(al.flush_o), 32'd0);
    tick();

    // 5: external flush against alloc + complete + ready retire
    set_alloc(1'b1, 32'h4000, 1'b1, 5'd1, 1'b0); tick();
    set_alloc(1'b1, 32'h4004, 1'b1, 5'd2, 1'b0); tick();
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    set_cmp(1'b1, 5'd1, 1'b0); tick();
    set_alloc(1'b1, 32'h4008, 1'b1, 5'd3, 1'b0);
    set_cmp(1'b1, 5'd2, 1'b0);
    al.flush_i = 1'b1; #1;
    chk("t5_no_retire", 32'(al.retire_valid), 32'd0);
    chk("t5_no_alloc", 32'(al.alloc_ready), 32'd0);
    tick();
    al.flush_i = 1'b0;
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    set_cmp(1'b0, '0, 1'b0);
    chk("t5_count0", 32'(al.count), 32'd0);
    chk("t5_index0", 32'(al.alloc_index), 32'd0);

    // 6: asynchronous reset in the middle of a cycle with live entries
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 32'h5000 + 32'(4 * i), 1'b1, 5'(i + 20), 1'b0);
      tick();
    end
    set_alloc(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    set_cmp(1'b1, 5'd0, 1'b0); tick();
    set_cmp(1'b0, '0, 1'b0);
    chk("t6_pre_count", 32'(al.count), 32'd5);
    chk("t6_pre_retire", 32'(al.retire_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_alloc_ready", 32'(al.alloc_ready), 32'd1);
    chk("t6_alloc_index", 32'(al.alloc_index), 32'd0);
    chk("t6_count", 32'(al.count), 32'd0);
    chk("t6_retire_valid", 32'(al.retire_valid), 32'd0);
    chk("t6_retire_pc", al.retire_pc, 32'd0);
    chk("t6_flush_o", 32'(al.flush_o), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
